conv_filter_scheduler: RTL and testbench

Sequences K convolution filters through N_ENG shared single-filter convolution engines, one group of N_ENG filters at a time. Drives the engines' common reset, selects which filter group feeds them, and pulses a capture strobe so the multi-filter output buffer latches each group's feature maps. Sits between the layer-level top and the engine array; replaces free-running counter sequencing with an explicit start/busy/done handshake.

---
 rtl/conv_sched_pkg.sv | 40 ++++
 rtl/conv_sched_if.sv | 26 ++
 rtl/conv_run_timer.sv | 24 ++
 rtl/conv_filter_scheduler.sv | 117 +++++++++++
 tb/tb_conv_filter_scheduler.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and width helpers for the convolution filter scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        CAPTURE,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int calc_ng(input int k, input int n_eng);
        return (k + n_eng - 1) / n_eng;
    endfunction

    function automatic int calc_gw(input int ng);
        int c;
        c = clog2(ng);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int calc_cw(input int run_cycles);
        int c;
        c = clog2(run_cycles + 1);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/conv_sched_if.sv
// Handshake and engine-control bundle between layer top, scheduler and engines.
interface conv_sched_if #(
    parameter int N_ENG = 2,
    parameter int GW    = 2
);
    logic             start;
    logic             busy;
    logic             done;
    logic             eng_reset;
    logic [GW-1:0]    filter_group;
    logic [N_ENG-1:0] eng_mask;
    logic             capture;
    logic [GW-1:0]    out_group;

    modport master (
        input  start,
        output busy, done, eng_reset, filter_group,
        output eng_mask, capture, out_group
    );

    modport slave (
        output start,
        input  busy, done, eng_reset, filter_group,
        input  eng_mask, capture, out_group
    );
endinterface

// File: rtl/conv_run_timer.sv
// Counts cycles an engine has been running; flags the last run cycle.
module conv_run_timer #(
    parameter int RUN_CYCLES = 1569,
    parameter int CW         = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // Leaves RUN on the flag, so the counter never needs to wrap.
    assign tc = en && (count == CW'(RUN_CYCLES - 1));
endmodule

// File: rtl/conv_filter_scheduler.sv
// Steps filter groups through the shared engines: prime, run, capture, repeat.
module conv_filter_scheduler
    import conv_sched_pkg::*;
#(
    parameter int K          = 6,
    parameter int N_ENG      = 2,
    parameter int RUN_CYCLES = 1569
) (
    input logic        clk,
    input logic        reset,
    conv_sched_if.master bus
);
    localparam int NG = calc_ng(K, N_ENG);
    localparam int GW = calc_gw(NG);
    localparam int CW = calc_cw(RUN_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(NG - 1);

    state_t           state;
    state_t           state_nx;
    logic [GW-1:0]    group;
    logic [N_ENG-1:0] mask;
    logic             tc;
    logic             last;

    function automatic logic [N_ENG-1:0] mask_of(input logic [GW-1:0] g);
        logic [N_ENG-1:0] m;
        m = '0;
        for (int i = 0; i < N_ENG; i++) begin
            m[i] = (int'(g) * N_ENG + i) < K;
        end
        return m;
    endfunction

    assign last = (group == LAST);

    conv_run_timer #(
        .RUN_CYCLES(RUN_CYCLES),
        .CW        (CW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(state != RUN),
        .en   (state == RUN),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = PRIME;
            PRIME:   state_nx = RUN;
            RUN:     if (tc) state_nx = CAPTURE;
            CAPTURE: state_nx = last ? DONE : PRIME;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Group and mask only move on edges that enter PRIME.
    always_ff @(posedge clk) begin
        if (reset) begin
            group <= '0;
            mask  <= mask_of('0);
        end else if (state == IDLE && bus.start) begin
            group <= '0;
            mask  <= mask_of('0);
        end else if (state == CAPTURE && !last) begin
            group <= group + GW'(1);
            mask  <= mask_of(group + GW'(1));
        end
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.eng_reset = 1'b1;
        bus.capture   = 1'b0;
        case (state)
            IDLE: begin
                bus.eng_reset = 1'b1;
            end
            PRIME: begin
                bus.busy      = 1'b1;
                bus.eng_reset = 1'b1;
            end
            RUN: begin
                bus.busy      = 1'b1;
                bus.eng_reset = 1'b0;
            end
            CAPTURE: begin
                bus.busy      = 1'b1;
                bus.eng_reset = 1'b0;
                bus.capture   = 1'b1;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.done      = 1'b1;
                bus.eng_reset = 1'b1;
            end
            default: begin
                bus.eng_reset = 1'b1;
            end
        endcase
    end

    assign bus.filter_group = group;
    assign bus.out_group    = group;
    assign bus.eng_mask     = mask;
endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Directed bench: three scheduler configurations driven from one clock.
module tb_conv_filter_scheduler;

    localparam int GWA = conv_sched_pkg::calc_gw(conv_sched_pkg::calc_ng(6, 2));
    localparam int GWB = conv_sched_pkg::calc_gw(conv_sched_pkg::calc_ng(5, 2));
    localparam int GWC = conv_sched_pkg::calc_gw(conv_sched_pkg::calc_ng(1, 2));

    logic clk;
    logic reset;

    conv_sched_if #(.N_ENG(2), .GW(GWA)) bus_a ();
    conv_sched_if #(.N_ENG(2), .GW(GWB)) bus_b ();
    conv_sched_if #(.N_ENG(2), .GW(GWC)) bus_c ();

    conv_filter_scheduler #(.K(6), .N_ENG(2), .RUN_CYCLES(4)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a.master)
    );

    conv_filter_scheduler #(.K(5), .N_ENG(2), .RUN_CYCLES(4)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b.master)
    );

    conv_filter_scheduler #(.K(1), .N_ENG(2), .RUN_CYCLES(1)) dut_c (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_c.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: busy, done, eng_reset, capture, group, mask, out_group.
    typedef struct {
        int         dut;
        int         n;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] obs_a[0:63];
    logic [9:0] obs_b[0:63];
    logic [9:0] obs_c[0:63];
    int         total;
    int         bad;

    function automatic logic [9:0] pk(
        input logic b, input logic d, input logic er, input logic cap,
        input logic [1:0] fg, input logic [1:0] m, input logic [1:0] og
    );
        return {b, d, er, cap, fg, m, (cap ? og : 2'b00)};
    endfunction

    function automatic logic [9:0] snap(input int dut);
        logic [9:0] v;
        if (dut == 0) begin
            v = pk(bus_a.busy, bus_a.done, bus_a.eng_reset, bus_a.capture,
                   bus_a.filter_group, bus_a.eng_mask, bus_a.out_group);
        end else if (dut == 1) begin
            v = pk(bus_b.busy, bus_b.done, bus_b.eng_reset, bus_b.capture,
                   bus_b.filter_group, bus_b.eng_mask, bus_b.out_group);
        end else begin
            v = pk(bus_c.busy, bus_c.done, bus_c.eng_reset, bus_c.capture,
                   {1'b0, bus_c.filter_group}, bus_c.eng_mask,
                   {1'b0, bus_c.out_group});
        end
        return v;
    endfunction

    function automatic logic [9:0] get_obs(input int dut, input int n);
        if (dut == 0) return obs_a[n];
        if (dut == 1) return obs_b[n];
        return obs_c[n];
    endfunction

    function automatic int cnt(input int dut, input int bitpos, input int lo, input int hi);
        int c;
        logic [9:0] v;
        c = 0;
        for (int n = lo; n <= hi; n++) begin
            v = get_obs(dut, n);
            if (v[bitpos]) c++;
        end
        return c;
    endfunction

    function automatic vec_t mk(
        input int dut, input int n, input logic b, input logic d,
        input logic er, input logic cap, input logic [1:0] fg,
        input logic [1:0] m, input logic [1:0] og
    );
        vec_t r;
        r.dut = dut;
        r.n   = n;
        r.exp = pk(b, d, er, cap, fg, m, og);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int ncyc, input bit hold);
        for (int n = 1; n <= ncyc; n++) begin
            step();
            if (n == 1 && !hold) begin
                bus_a.start = 1'b0;
                bus_b.start = 1'b0;
                bus_c.start = 1'b0;
            end
            obs_a[n] = snap(0);
            obs_b[n] = snap(1);
            obs_c[n] = snap(2);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;

        // K=6 groups 0..2, full masks
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 5, 1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 6, 1, 0, 0, 1, 0, 3, 0));
        tbl.push_back(mk(0, 7, 1, 0, 1, 0, 1, 3, 0));
        tbl.push_back(mk(0, 12, 1, 0, 0, 1, 1, 3, 1));
        tbl.push_back(mk(0, 13, 1, 0, 1, 0, 2, 3, 0));
        tbl.push_back(mk(0, 18, 1, 0, 0, 1, 2, 3, 2));
        tbl.push_back(mk(0, 19, 1, 1, 1, 0, 2, 3, 0));
        tbl.push_back(mk(0, 20, 0, 0, 1, 0, 2, 3, 0));
        // K=5: last group drops engine 1
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(1, 7, 1, 0, 1, 0, 1, 3, 0));
        tbl.push_back(mk(1, 12, 1, 0, 0, 1, 1, 3, 1));
        tbl.push_back(mk(1, 13, 1, 0, 1, 0, 2, 1, 0));
        tbl.push_back(mk(1, 16, 1, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(1, 18, 1, 0, 0, 1, 2, 1, 2));
        tbl.push_back(mk(1, 19, 1, 1, 1, 0, 2, 1, 0));
        // K=1, single group, one run cycle
        tbl.push_back(mk(2, 1, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(2, 2, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(2, 3, 1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(2, 4, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(2, 5, 0, 0, 1, 0, 0, 1, 0));

        step();
        step();
        step();
        chk("reset_a", 32'(snap(0)), 32'(pk(0, 0, 1, 0, 0, 3, 0)));
        chk("reset_b", 32'(snap(1)), 32'(pk(0, 0, 1, 0, 0, 3, 0)));
        chk("reset_c", 32'(snap(2)), 32'(pk(0, 0, 1, 0, 0, 1, 0)));
        reset = 1'b0;

        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("idle_c%0d", i),
                32'({snap(0), snap(1), snap(2)}),
                32'({pk(0, 0, 1, 0, 0, 3, 0), pk(0, 0, 1, 0, 0, 3, 0),
                     pk(0, 0, 1, 0, 0, 1, 0)}));
        end

        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        bus_c.start = 1'b1;
        run(24, 1'b0);
        foreach (tbl[i]) begin
            chk($sformatf("tbl_dut%0d_n%0d", tbl[i].dut, tbl[i].n),
                32'(get_obs(tbl[i].dut, tbl[i].n)), 32'(tbl[i].exp));
        end
        chk("caps_a", cnt(0, 6, 1, 24), 3);
        chk("caps_b", cnt(1, 6, 1, 24), 3);
        chk("caps_c", cnt(2, 6, 1, 24), 1);
        chk("dones_a", cnt(0, 8, 1, 24), 1);
        chk("dones_b", cnt(1, 8, 1, 24), 1);
        chk("dones_c", cnt(2, 8, 1, 24), 1);

        // start held high: IDLE cycle after DONE launches a second run
        bus_a.start = 1'b1;
        run(30, 1'b1);
        bus_a.start = 1'b0;
        chk("hold_done", 32'(obs_a[19]), 32'(pk(1, 1, 1, 0, 2, 3, 0)));
        chk("hold_idle", 32'(obs_a[20]), 32'(pk(0, 0, 1, 0, 2, 3, 0)));
        chk("hold_prime", 32'(obs_a[21]), 32'(pk(1, 0, 1, 0, 0, 3, 0)));
        chk("hold_cap", 32'(obs_a[26]), 32'(pk(1, 0, 0, 1, 0, 3, 0)));
        chk("hold_caps", cnt(0, 6, 1, 20), 3);
        chk("hold_dones", cnt(0, 8, 1, 20), 1);
        budget = 0;
        while (bus_a.busy && budget < 100) begin
            step();
            budget++;
        end
        chk("hold_drain_timeout", 32'(bus_a.busy), 32'(0));

        // reset while group 1 is running
        bus_b.start = 1'b1;
        run(9, 1'b0);
        chk("mid_run", 32'(obs_b[9]), 32'(pk(1, 0, 0, 0, 1, 3, 0)));
        reset = 1'b1;
        step();
        chk("mid_reset", 32'(snap(1)), 32'(pk(0, 0, 1, 0, 0, 3, 0)));
        reset = 1'b0;
        run(30, 1'b0);
        chk("abort_caps", cnt(1, 6, 1, 30), 0);
        chk("abort_dones", cnt(1, 8, 1, 30), 0);
        chk("abort_idle", 32'(obs_b[30]), 32'(pk(0, 0, 1, 0, 0, 3, 0)));

        bus_b.start = 1'b1;
        run(24, 1'b0);
        chk("rerun_cap0", 32'(obs_b[6]), 32'(pk(1, 0, 0, 1, 0, 3, 0)));
        chk("rerun_cap1", 32'(obs_b[12]), 32'(pk(1, 0, 0, 1, 1, 3, 1)));
        chk("rerun_cap2", 32'(obs_b[18]), 32'(pk(1, 0, 0, 1, 2, 1, 2)));
        chk("rerun_done", 32'(obs_b[19]), 32'(pk(1, 1, 1, 0, 2, 1, 0)));
        chk("rerun_caps", cnt(1, 6, 1, 24), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
